// File: rtl/decoder_strobe_if.sv
// rtl/decoder_strobe_if.sv - request handshake and strobe outputs of decoder_strobe
interface decoder_strobe_if #(
  parameter int SEL_W  = 3,
  parameter int N_OUT  = 8,
  parameter int HOLD_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  sel;
  logic [HOLD_W-1:0] hold;
  logic [N_OUT-1:0]  y;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output in_valid, sel, hold,
    input  in_ready, y, busy, done, err
  );

  modport slave (
    input  in_valid, sel, hold,
    output in_ready, y, busy, done, err
  );
endinterface

// File: rtl/decoder_strobe.sv
// rtl/decoder_strobe.sv - registered one-hot strobe decoder with hold count and back-to-back issue
// Optional: DECODER_STROBE_RANGE_CHECK_EN pulses err for an out-of-range select.
module decoder_strobe #(
  parameter int SEL_W  = 3,
  parameter int N_OUT  = 8,
  parameter int HOLD_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  decoder_strobe_if.slave bus
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [N_OUT-1:0]  y_q, y_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [HOLD_W-1:0] hold_m1;
  logic              accept;
  logic              in_range;

  // Ready in IDLE, or on the last cycle of a strobe so the next one follows with no gap.
  assign bus.in_ready = (state_q == S_IDLE) || (cnt_q == '0);
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_range     = 32'(bus.sel) < 32'(N_OUT);
  assign hold_m1      = (bus.hold == '0) ? '0 : bus.hold - HOLD_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (accept) begin
      if (in_range) begin
        y_d     = N_OUT'(1) << bus.sel;
        cnt_d   = hold_m1;
        busy_d  = 1'b1;
        done_d  = (hold_m1 == '0);
        state_d = S_ACTIVE;
      end else begin
        y_d     = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    end else if (state_q == S_ACTIVE) begin
      if (cnt_q != '0) begin
        cnt_d  = cnt_q - HOLD_W'(1);
        done_d = (cnt_q == HOLD_W'(1));
      end else begin
        y_d     = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

`ifdef DECODER_STROBE_RANGE_CHECK_EN
  logic err_q, err_d;

  assign err_d = accept && !in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_decoder_strobe.sv
// tb/tb_decoder_strobe.sv - vector table, corner sequences and random run against a timeline model
module tb_decoder_strobe;
  localparam int SEL_W  = 3;
  localparam int N_OUT  = 6;
  localparam int HOLD_W = 4;
  localparam int MAXC   = 8192;
`ifdef DECODER_STROBE_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    bit             v;
    int             s;
    int             h;
    logic [N_OUT-1:0] y;
    bit             b;
    bit             d;
    bit             e;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  decoder_strobe_if #(.SEL_W(SEL_W), .N_OUT(N_OUT), .HOLD_W(HOLD_W)) bus ();

  decoder_strobe #(.SEL_W(SEL_W), .N_OUT(N_OUT), .HOLD_W(HOLD_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  // Expected per-cycle picture: which line is high, and where done/err pulse.
  int   exp_line [MAXC];
  bit   exp_done [MAXC];
  bit   exp_err  [MAXC];
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
  endtask

  function automatic logic [N_OUT-1:0] line2y(input int l);
    logic [N_OUT-1:0] r;
    r = '0;
    if (l >= 0) r[l] = 1'b1;
    return r;
  endfunction

  task automatic clear_model();
    for (int i = cyc; i < cyc + 20 && i < MAXC; i++) begin
      exp_line[i] = -1;
      exp_done[i] = 1'b0;
      exp_err[i]  = 1'b0;
    end
  endtask

  task automatic step(input bit v, input int s, input int h);
    bit rdy;
    int hh;
    bus.in_valid = v;
    bus.sel      = SEL_W'(s);
    bus.hold     = HOLD_W'(h);
    #1;
    rdy = (exp_line[cyc] < 0) || exp_done[cyc];
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    if (v && rdy) begin
      hh = (h == 0) ? 1 : h;
      if (s < N_OUT) begin
        for (int j = 1; j <= hh; j++) exp_line[cyc + j] = s;
        exp_done[cyc + hh] = 1'b1;
      end else begin
        exp_err[cyc + 1] = RC;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("y",    32'(bus.y),    32'(line2y(exp_line[cyc])));
    chk("busy", 32'(bus.busy), 32'(exp_line[cyc] >= 0));
    chk("done", 32'(bus.done), 32'(exp_done[cyc]));
    chk("err",  32'(bus.err),  32'(exp_err[cyc]));
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_y",        32'(bus.y),        32'(0));
    chk("rst_busy",     32'(bus.busy),     32'(0));
    chk("rst_done",     32'(bus.done),     32'(0));
    chk("rst_err",      32'(bus.err),      32'(0));
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic add(input bit v, input int s, input int h, input logic [N_OUT-1:0] y,
                     input bit b, input bit d, input bit e);
    vec_t t;
    t.v = v; t.s = s; t.h = h; t.y = y; t.b = b; t.d = d; t.e = e;
    tbl.push_back(t);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int dn;
    int hsel;
    for (int i = 0; i < MAXC; i++) begin
      exp_line[i] = -1;
      exp_done[i] = 1'b0;
      exp_err[i]  = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.sel      = '0;
    bus.hold     = '0;
    #2;
    do_reset();

    add(1, 5, 3, 6'b100000, 1, 0, 0);
    add(0, 0, 0, 6'b100000, 1, 0, 0);
    add(0, 0, 0, 6'b100000, 1, 1, 0);
    add(0, 0, 0, 6'b000000, 0, 0, 0);
    add(1, 0, 0, 6'b000001, 1, 1, 0);
    add(0, 0, 0, 6'b000000, 0, 0, 0);
    add(1, 2, 2, 6'b000100, 1, 0, 0);
    add(1, 4, 1, 6'b000100, 1, 1, 0);
    add(1, 4, 1, 6'b010000, 1, 1, 0);
    add(0, 0, 0, 6'b000000, 0, 0, 0);
    add(1, 7, 5, 6'b000000, 0, 0, 1);
    add(0, 0, 0, 6'b000000, 0, 0, 0);
    add(1, 3, 4, 6'b001000, 1, 0, 0);
    add(1, 1, 2, 6'b001000, 1, 0, 0);
    add(0, 0, 0, 6'b001000, 1, 0, 0);
    add(0, 0, 0, 6'b001000, 1, 1, 0);
    add(1, 3, 2, 6'b001000, 1, 0, 0);
    add(1, 6, 1, 6'b001000, 1, 1, 0);
    add(1, 6, 1, 6'b000000, 0, 0, 1);
    add(0, 0, 0, 6'b000000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].h);
      chk($sformatf("tbl_y[%0d]", i),    32'(bus.y),    32'(tbl[i].y));
      chk($sformatf("tbl_busy[%0d]", i), 32'(bus.busy), 32'(tbl[i].b));
      chk($sformatf("tbl_done[%0d]", i), 32'(bus.done), 32'(tbl[i].d));
      chk($sformatf("tbl_err[%0d]", i),  32'(bus.err),  32'(tbl[i].e & RC));
    end

    // Longest strobe: 15 cycles high, one done, then low.
    step(1, 1, 15);
    hi = int'(bus.y[1]);
    dn = int'(bus.done);
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 0);
      hi += int'(bus.y[1]);
      dn += int'(bus.done);
    end
    chk("max_hold_len",  32'(hi), 32'(15));
    chk("max_hold_done", 32'(dn), 32'(1));

    // Reset in the 2nd cycle of a 10-cycle strobe.
    step(1, 2, 10);
    step(0, 0, 0);
    do_reset();
    step(0, 0, 0);
    chk("post_rst_y", 32'(bus.y), 32'(0));

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) hsel = $urandom_range(0, 15);
      else hsel = $urandom_range(0, 3);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 7), hsel);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/decoder_strobe.md
# decoder_strobe

Registered, parametrised N-output one-hot strobe decoder for the tiny MIPS CPU's memory-mapped I/O path. Accepts a select code through a valid/ready handshake and drives exactly one output line high for a programmable number of cycles, with a one-cycle completion pulse. It sits between the bus address stage and the peripheral chip-select / write-enable lines. It supersedes the purely combinational 3-to-8 decoding by adding width/count parameters, hold timing, back-to-back issue and range checking.

## Interface
- `SEL_W`, default 3, select code width.
- `N_OUT`, default 8, number of outputs; legal range 1..2^SEL_W.
- `HOLD_W`, default 4, width of the hold-count input.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request this cycle (combinational from state).
- `sel`  in  SEL_W  select code; sampled on acceptance.
- `hold`  in  HOLD_W  strobe length in cycles; 0 is treated as 1; sampled on acceptance.
- `y`  out  N_OUT  registered one-hot strobe outputs.
- `busy`  out  1  registered; high while a strobe is active.
- `done`  out  1  registered; one-cycle pulse on the last cycle of a strobe.
- `err`  out  1  registered; one-cycle pulse for an out-of-range select (see Configuration).

## Operation
- Acceptance is `in_valid && in_ready` at a rising edge. `sel` and `hold` are sampled at that edge.
- There are two states, IDLE and ACTIVE. A countdown register `cnt` is HOLD_W bits wide.
- **IDLE**
  - `in_ready` = 1.
  - On acceptance with `sel < N_OUT`:
    - `y` <= one-hot(`sel`), so `y[sel]` = 1 and all other bits are 0.
    - `cnt` <= max(`hold`,1) - 1.
    - `busy` <= 1, and the state moves to ACTIVE.
- **ACTIVE**
  - `in_ready` = (`cnt` == 0).
  - `done` = 1 exactly when `cnt` == 0. It is registered, so it is set on the edge that loads or decrements `cnt` to 0.
  - If `cnt` != 0: `cnt` <= `cnt` - 1.
  - If `cnt` == 0 and no acceptance: `y` <= 0, `busy` <= 0, state -> IDLE.
  - If `cnt` == 0 with acceptance: this is a back-to-back issue.
    - `y` switches directly to the new one-hot value with no zero cycle.
    - `cnt` is reloaded and the state stays ACTIVE.
    - If the new select is the same line, `y` stays high continuously.
- **Out-of-range** (`sel >= N_OUT`) handling is described in Configuration. Only possible when N_OUT < 2^SEL_W.
- `y` never has more than one bit set.
- `in_valid` while `in_ready` = 0 is ignored. The requester must hold it.

## Timing
- Accept at edge k -> `y`/`busy` high from edge k through edge k+H, where H = max(`hold`,1). That is H cycles high; low after edge k+H unless re-issued.
- `done` is high for exactly one cycle: the cycle between edges k+H-1 and k+H.
- Back-to-back: the earliest next acceptance is edge k+H. Throughput is one strobe per H cycles with no gaps.
- `hold` = 0 and `hold` = 1 behave identically: a one-cycle strobe, with `done` coincident with `y`.
- `hold` = 2^HOLD_W - 1 gives the maximum strobe; `cnt` never wraps.
- Reset (any time, including mid-strobe):
  - `y` = 0, `busy` = 0, `done` = 0, `err` = 0, `cnt` = 0, state = IDLE.
  - `in_ready` = 1 immediately.
  - Release is synchronised by the integrator. The block assumes a clean deassertion.

## Configuration
- Macro `DECODER_STROBE_RANGE_CHECK_EN`.
- **Defined:** an out-of-range select is still accepted (`in_ready` behaviour unchanged).
  - `err` pulses high for one cycle after the accepting edge.
  - `y` <= 0, `busy` <= 0, and the state goes to (or stays in) IDLE.
  - This also applies as the back-to-back request from ACTIVE.
- **Undefined:** an out-of-range select is accepted and silently dropped, with the same `y`/`busy`/state effect. `err` is tied to 0.

## Test plan
- SEL_W=3, N_OUT=8: reset, then `sel`=5, `hold`=3 -> `y`=8'b0010_0000 for 3 cycles, `done` in the 3rd, `busy` mirrors `y`, then `y`=0.
- `hold`=0 with `sel`=0 -> `y`=8'b0000_0001 for 1 cycle, `done` in the same cycle.
- Back-to-back: `sel`=2 `hold`=2, with `in_valid` held for `sel`=6 `hold`=1 -> `y` bit 2 for 2 cycles, then immediately bit 6 for 1 cycle; `done` pulses twice; no zero gap.
- N_OUT=6 with the macro defined: `sel`=7 -> `err` 1 cycle, `y`=0, `busy`=0. Without the macro -> `err` stays 0.
- Assert `rst_n`=0 in the 2nd cycle of a `hold`=10 strobe -> `y`, `busy` and `done` drop immediately; `in_ready`=1.
- `in_valid` pulsed while `busy` and `cnt` != 0 -> ignored; `y` unchanged.
